// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame constants and the
// default bit period, used by both UART1 and UART2.
package uart_pkg;

  localparam int DATA_BITS        = 8;
  localparam bit PARITY_EVEN      = 1'b1;
  localparam int CLKS_PER_BIT_DEF = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Even parity: the parity bit equals the XOR of the data bits.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return PARITY_EVEN ? ^d : ~^d;
  endfunction

endpackage

// File: rtl/uart2_rx_if.sv
// Receiver-side signal bundle: serial line in, received byte plus status out.
interface uart2_rx_if;
  import uart_pkg::*;

  logic                 rx2;
  logic                 rx_ack;
  logic [DATA_BITS-1:0] data_out;
  logic                 rx_valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;
  uart_state_e          state;

  // Handshake: rx_valid rises when a frame completes and stays high until the
  // consumer holds rx_ack high at a clock edge where rx_valid is already high;
  // data_out and the error flags are stable while rx_valid is high unless a
  // newer frame overwrites them (which also raises overrun).
  modport master (
    input  rx2, rx_ack,
    output data_out, rx_valid, parity_err, frame_err, overrun, busy, state
  );

  modport slave (
    output rx2, rx_ack,
    input  data_out, rx_valid, parity_err, frame_err, overrun, busy, state
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line plus a falling-edge
// detector that stays disarmed after reset until the real line is seen high.
module uart_rx_sync (
  input  logic clk_uart,
  input  logic rst,
  input  logic rx_async,
  output logic rx_sync,
  output logic rx_fall
);

  logic       sync_1;
  logic       sync_2;
  logic       prev;
  logic [1:0] fill;
  logic       armed;

  // fill tracks when sync_2 holds a real line sample rather than its reset
  // value, so a line that is low out of reset is not mistaken for a start.
  always_ff @(posedge clk_uart) begin
    if (rst) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
      prev   <= 1'b1;
      fill   <= 2'b00;
      armed  <= 1'b0;
    end else begin
      sync_1 <= rx_async;
      sync_2 <= sync_1;
      prev   <= sync_2;
      fill   <= {fill[0], 1'b1};
      if (fill[1] && sync_2) begin
        armed <= 1'b1;
      end
    end
  end

  assign rx_sync = sync_2;
  assign rx_fall = armed & prev & ~sync_2;

endmodule

// File: rtl/uart2_rx.sv
// UART2 receiver: 8 data bits LSB first, even parity, one stop bit; delivers
// each byte with its parity/framing status through a valid/ack handshake.
module uart2_rx
  import uart_pkg::*;
#(
  // clk_uart cycles per serial bit; even, 4..256
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk_uart,
  input  logic       rst,
  uart2_rx_if.master rx_if
);

  localparam int CW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW    = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  logic                 rx_s;
  logic                 rx_fall;
  uart_state_e          state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic [DATA_BITS-1:0] data_r;
  logic                 rx_valid_r;
  logic                 parity_err_r;
  logic                 frame_err_r;
  logic                 overrun_r;

  uart_rx_sync u_sync (
    .clk_uart (clk_uart),
    .rst      (rst),
    .rx_async (rx_if.rx2),
    .rx_sync  (rx_s),
    .rx_fall  (rx_fall)
  );

  always_ff @(posedge clk_uart) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      par_bit      <= 1'b0;
      data_r       <= '0;
      rx_valid_r   <= 1'b0;
      parity_err_r <= 1'b0;
      frame_err_r  <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      // Acknowledge path; a frame completing on the same edge overrides it.
      if (rx_if.rx_ack && rx_valid_r) begin
        rx_valid_r <= 1'b0;
        overrun_r  <= 1'b0;
      end

      case (state)
        IDLE: begin
          cnt <= '0;
          if (rx_fall) begin
            state <= START;
          end
        end

        START: begin
          if (cnt == CNT_HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            if (bit_idx == IDX_LAST) begin
              state <= PARITY;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        PARITY: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            par_bit <= rx_s;
            state   <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STOP: begin
          // Leave at mid stop bit so a back-to-back start edge is not missed.
          if (cnt == CNT_LAST) begin
            cnt          <= '0;
            state        <= IDLE;
            data_r       <= shreg;
            parity_err_r <= (par_bit != parity_of(shreg));
            frame_err_r  <= ~rx_s;
            rx_valid_r   <= 1'b1;
            if (rx_if.rx_ack) begin
              overrun_r <= 1'b0;
            end else if (rx_valid_r) begin
              overrun_r <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign rx_if.data_out   = data_r;
  assign rx_if.rx_valid   = rx_valid_r;
  assign rx_if.parity_err = parity_err_r;
  assign rx_if.frame_err  = frame_err_r;
  assign rx_if.overrun    = overrun_r;
  assign rx_if.busy       = (state != IDLE);
  assign rx_if.state      = state;

endmodule

// File: tb/tb_uart2_rx.sv
// Bench for uart2_rx: directed frames plus randomized frames scored against
// a frame-level model {data, parity mismatch, stop bit low}.
module tb_uart2_rx;
  import uart_pkg::*;

  localparam int CPB = 16;

  logic clk_uart = 1'b0;
  logic rst      = 1'b1;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  logic [9:0] exp_q[$];

  uart2_rx_if rx_if();

  uart2_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk_uart (clk_uart),
    .rst      (rst),
    .rx_if    (rx_if)
  );

  // clock / reset
  always #5 clk_uart = ~clk_uart;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(posedge clk_uart);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
    logic [10:0] bits;
    bits = {stp, par, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rx_if.rx2 = bits[i];
      cyc(CPB);
    end
  endtask

  task automatic ack_pulse();
    rx_if.rx_ack = 1'b1;
    cyc(1);
    rx_if.rx_ack = 1'b0;
  endtask

  // reference model: what a correct receiver reports for one frame
  function automatic logic [9:0] model(input logic [7:0] d, input logic par, input logic stp);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += d[i];
    return {d, (par != ((ones % 2) == 1)), ~stp};
  endfunction

  task automatic test_reset();
    rst = 1'b1; rx_if.rx2 = 1'b1; rx_if.rx_ack = 1'b0;
    cyc(4);
    @(negedge clk_uart);
    chk_cnt++; if (rx_if.data_out !== 8'h00) $display("FAIL reset_data got %h want 00", rx_if.data_out); else pass_cnt++;
    chk_cnt++; if (rx_if.rx_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", rx_if.rx_valid); else pass_cnt++;
    chk_cnt++; if (rx_if.parity_err !== 1'b0) $display("FAIL reset_perr got %b want 0", rx_if.parity_err); else pass_cnt++;
    chk_cnt++; if (rx_if.frame_err !== 1'b0) $display("FAIL reset_ferr got %b want 0", rx_if.frame_err); else pass_cnt++;
    chk_cnt++; if (rx_if.overrun !== 1'b0) $display("FAIL reset_overrun got %b want 0", rx_if.overrun); else pass_cnt++;
    chk_cnt++; if (rx_if.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", rx_if.busy); else pass_cnt++;
    chk_cnt++; if (rx_if.state !== IDLE) $display("FAIL reset_state got %0d want IDLE", rx_if.state); else pass_cnt++;
    cyc(1);
    rst = 1'b0;
    cyc(2 * CPB);
  endtask

  task automatic test_basic();
    int lat;
    lat = -1;
    fork
      send_frame(8'hA5, 1'b0, 1'b1);
      begin
        for (int i = 0; i < 12 * CPB; i++) begin
          @(negedge clk_uart);
          if (rx_if.rx_valid && lat < 0) lat = i;
        end
      end
    join
    chk_cnt++; if (lat < 10 * CPB || lat > 11 * CPB + 4) $display("FAIL basic_latency got %0d want %0d..%0d", lat, 10 * CPB, 11 * CPB + 4); else pass_cnt++;
    chk_cnt++; if (rx_if.data_out !== 8'hA5) $display("FAIL basic_data got %h want a5", rx_if.data_out); else pass_cnt++;
    chk_cnt++; if (rx_if.rx_valid !== 1'b1) $display("FAIL basic_valid got %b want 1", rx_if.rx_valid); else pass_cnt++;
    chk_cnt++; if (rx_if.parity_err !== 1'b0) $display("FAIL basic_perr got %b want 0", rx_if.parity_err); else pass_cnt++;
    chk_cnt++; if (rx_if.frame_err !== 1'b0) $display("FAIL basic_ferr got %b want 0", rx_if.frame_err); else pass_cnt++;
    ack_pulse();
    @(negedge clk_uart);
    chk_cnt++; if (rx_if.rx_valid !== 1'b0) $display("FAIL basic_ack_valid got %b want 0", rx_if.rx_valid); else pass_cnt++;
    cyc(CPB);
  endtask

  task automatic test_parity();
    send_frame(8'h01, 1'b0, 1'b1);
    @(negedge clk_uart);
    chk_cnt++; if (rx_if.data_out !== 8'h01) $display("FAIL parity_data got %h want 01", rx_if.data_out); else pass_cnt++;
    chk_cnt++; if (rx_if.rx_valid !== 1'b1) $display("FAIL parity_valid got %b want 1", rx_if.rx_valid); else pass_cnt++;
    chk_cnt++; if (rx_if.parity_err !== 1'b1) $display("FAIL parity_perr got %b want 1", rx_if.parity_err); else pass_cnt++;
    chk_cnt++; if (rx_if.frame_err !== 1'b0) $display("FAIL parity_ferr got %b want 0", rx_if.frame_err); else pass_cnt++;
    ack_pulse();
    cyc(CPB);
  endtask

  task automatic test_break();
    int   events;
    logic prev_v;
    events = 0;
    prev_v = rx_if.rx_valid;
    fork
      begin
        send_frame(8'h3C, 1'b0, 1'b0);
        cyc(40 * CPB);
      end
      begin
        for (int i = 0; i < 51 * CPB; i++) begin
          @(negedge clk_uart);
          if (rx_if.rx_valid && !prev_v) events++;
          prev_v = rx_if.rx_valid;
        end
      end
    join
    @(negedge clk_uart);
    chk_cnt++; if (events != 1) $display("FAIL break_events got %0d want 1", events); else pass_cnt++;
    chk_cnt++; if (rx_if.data_out !== 8'h3C) $display("FAIL break_data got %h want 3c", rx_if.data_out); else pass_cnt++;
    chk_cnt++; if (rx_if.frame_err !== 1'b1) $display("FAIL break_ferr got %b want 1", rx_if.frame_err); else pass_cnt++;
    chk_cnt++; if (rx_if.busy !== 1'b0) $display("FAIL break_busy got %b want 0", rx_if.busy); else pass_cnt++;
    rx_if.rx2 = 1'b1;
    ack_pulse();
    cyc(2 * CPB);
    @(negedge clk_uart);
    chk_cnt++; if (rx_if.rx_valid !== 1'b0) $display("FAIL break_release_valid got %b want 0", rx_if.rx_valid); else pass_cnt++;
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 1'b0, 1'b1);
    cyc(CPB);
    send_frame(8'h22, 1'b0, 1'b1);
    @(negedge clk_uart);
    chk_cnt++; if (rx_if.data_out !== 8'h22) $display("FAIL overrun_data got %h want 22", rx_if.data_out); else pass_cnt++;
    chk_cnt++; if (rx_if.rx_valid !== 1'b1) $display("FAIL overrun_valid got %b want 1", rx_if.rx_valid); else pass_cnt++;
    chk_cnt++; if (rx_if.overrun !== 1'b1) $display("FAIL overrun_flag got %b want 1", rx_if.overrun); else pass_cnt++;
    ack_pulse();
    @(negedge clk_uart);
    chk_cnt++; if (rx_if.rx_valid !== 1'b0) $display("FAIL overrun_ack_valid got %b want 0", rx_if.rx_valid); else pass_cnt++;
    chk_cnt++; if (rx_if.overrun !== 1'b0) $display("FAIL overrun_ack_flag got %b want 0", rx_if.overrun); else pass_cnt++;
    cyc(CPB);
  endtask

  task automatic test_glitch();
    int  waited;
    logic seen_valid;
    rx_if.rx2 = 1'b0;
    cyc(6);
    rx_if.rx2 = 1'b1;
    waited = 0;
    @(negedge clk_uart);
    while (rx_if.busy && waited < 10) begin
      @(negedge clk_uart);
      waited++;
    end
    chk_cnt++; if (rx_if.busy !== 1'b0) $display("FAIL glitch_busy got %b want 0 within 10 cycles", rx_if.busy); else pass_cnt++;
    seen_valid = 1'b0;
    for (int i = 0; i < 2 * CPB; i++) begin
      @(negedge clk_uart);
      if (rx_if.rx_valid) seen_valid = 1'b1;
    end
    chk_cnt++; if (seen_valid !== 1'b0) $display("FAIL glitch_valid got %b want 0", seen_valid); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [10:0] bits;
    logic        seen_valid;
    bits = {1'b1, 1'b0, 8'h5A, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rx_if.rx2 = bits[i];
      cyc(CPB);
    end
    rx_if.rx2 = bits[5];
    cyc(CPB / 2);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    rx_if.rx2 = 1'b1;
    @(negedge clk_uart);
    chk_cnt++; if (rx_if.busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", rx_if.busy); else pass_cnt++;
    seen_valid = 1'b0;
    for (int i = 0; i < 2 * CPB; i++) begin
      @(negedge clk_uart);
      if (rx_if.rx_valid) seen_valid = 1'b1;
    end
    chk_cnt++; if (seen_valid !== 1'b0) $display("FAIL rstmid_partial got %b want 0", seen_valid); else pass_cnt++;
    cyc(1);
    send_frame(8'hC3, 1'b0, 1'b1);
    @(negedge clk_uart);
    chk_cnt++; if (rx_if.data_out !== 8'hC3) $display("FAIL rstmid_data got %h want c3", rx_if.data_out); else pass_cnt++;
    chk_cnt++; if (rx_if.rx_valid !== 1'b1) $display("FAIL rstmid_valid got %b want 1", rx_if.rx_valid); else pass_cnt++;
    chk_cnt++; if ({rx_if.parity_err, rx_if.frame_err, rx_if.overrun} !== 3'b000) $display("FAIL rstmid_flags got %b want 000", {rx_if.parity_err, rx_if.frame_err, rx_if.overrun}); else pass_cnt++;
    ack_pulse();
    cyc(CPB);
  endtask

  task automatic test_random_gapped();
    logic [7:0] d;
    logic       par;
    logic       stp;
    logic [9:0] exp;
    for (int n = 0; n < 12; n++) begin
      d   = 8'($urandom_range(0, 255));
      par = (^d) ^ ($urandom_range(0, 3) == 0);
      stp = ($urandom_range(0, 3) != 0);
      exp_q.push_back(model(d, par, stp));
      send_frame(d, par, stp);
      @(negedge clk_uart);
      exp = exp_q.pop_front();
      chk_cnt++; if (rx_if.rx_valid !== 1'b1) $display("FAIL rand_valid[%0d] got %b want 1", n, rx_if.rx_valid); else pass_cnt++;
      chk_cnt++; if (rx_if.data_out !== exp[9:2]) $display("FAIL rand_data[%0d] got %h want %h", n, rx_if.data_out, exp[9:2]); else pass_cnt++;
      chk_cnt++; if (rx_if.parity_err !== exp[1]) $display("FAIL rand_perr[%0d] got %b want %b", n, rx_if.parity_err, exp[1]); else pass_cnt++;
      chk_cnt++; if (rx_if.frame_err !== exp[0]) $display("FAIL rand_ferr[%0d] got %b want %b", n, rx_if.frame_err, exp[0]); else pass_cnt++;
      ack_pulse();
      rx_if.rx2 = 1'b1;
      cyc(2 * CPB);
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 16;
    int         got;
    int         budget;
    logic [7:0] d;
    logic       par;
    logic [9:0] exp;
    got    = 0;
    budget = 0;
    fork
      begin
        for (int n = 0; n < N; n++) begin
          d   = 8'($urandom_range(0, 255));
          par = (^d) ^ $urandom_range(0, 1);
          exp_q.push_back(model(d, par, 1'b1));
          send_frame(d, par, 1'b1);
        end
      end
      begin
        while (got < N && budget < N * 12 * CPB + 200) begin
          @(negedge clk_uart);
          budget++;
          rx_if.rx_ack = 1'b0;
          if (rx_if.rx_valid) begin
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3FF;
            chk_cnt++; if (rx_if.data_out !== exp[9:2]) $display("FAIL b2b_data[%0d] got %h want %h", got, rx_if.data_out, exp[9:2]); else pass_cnt++;
            chk_cnt++; if (rx_if.parity_err !== exp[1]) $display("FAIL b2b_perr[%0d] got %b want %b", got, rx_if.parity_err, exp[1]); else pass_cnt++;
            chk_cnt++; if (rx_if.frame_err !== exp[0]) $display("FAIL b2b_ferr[%0d] got %b want %b", got, rx_if.frame_err, exp[0]); else pass_cnt++;
            chk_cnt++; if (rx_if.overrun !== 1'b0) $display("FAIL b2b_overrun[%0d] got %b want 0", got, rx_if.overrun); else pass_cnt++;
            rx_if.rx_ack = 1'b1;
            got++;
          end
        end
        @(negedge clk_uart);
        rx_if.rx_ack = 1'b0;
      end
    join
    chk_cnt++; if (got != N) $display("FAIL b2b_count got %0d want %0d", got, N); else pass_cnt++;
    chk_cnt++; if (exp_q.size() != 0) $display("FAIL b2b_leftover got %0d want 0", exp_q.size()); else pass_cnt++;
    cyc(CPB);
  endtask

  initial begin
    rx_if.rx2    = 1'b1;
    rx_if.rx_ack = 1'b0;
    test_reset();
    test_basic();
    test_parity();
    test_break();
    test_overrun();
    test_glitch();
    test_reset_mid();
    test_random_gapped();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
